uart_cmd_frame_gen: RTL and testbench

UART_CMD_FRAME_GEN -- requirements
Module: uart_cmd_frame_gen

---
 rtl/uart_cmd_frame_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_cmd_frame_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_frame_gen.sv
// Multi-frame UART transmitter: one accepted command sends 1..MAX_FRAMES frames
// with optional parity, one or two stop bits and programmable idle gaps.
module uart_cmd_frame_gen #(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_FRAMES      = 4,
  parameter int FRAME_CNT_WIDTH = 3
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             i_baud_tick,
  input  logic                             i_start,
  input  logic [FRAME_CNT_WIDTH-1:0]       i_frame_cnt,
  input  logic [MAX_FRAMES*DATA_WIDTH-1:0] i_cmd_data,
  input  logic                             i_par_en,
  input  logic                             i_par_type,
  input  logic                             i_stop2,
  input  logic [3:0]                       i_gap_bits,
  output logic                             o_tx,
  output logic                             o_busy,
  output logic                             o_frame_done,
  output logic                             o_done,
  output logic [FRAME_CNT_WIDTH-1:0]       o_frame_idx
);

  localparam int CMD_W = MAX_FRAMES * DATA_WIDTH;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t                     state_q, state_d;
  logic                       tx_q, tx_d;
  logic                       pend_q, pend_d;
  logic [DATA_WIDTH-1:0]      sh_q, sh_d;
  logic [CMD_W-1:0]           data_q, data_d;
  logic                       par_q, par_d;
  logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic                       stop2nd_q, stop2nd_d;
  logic [3:0]                 gap_cnt_q, gap_cnt_d;
  logic [FRAME_CNT_WIDTH-1:0] idx_q, idx_d;
  logic [FRAME_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       par_en_q, par_en_d;
  logic                       par_type_q, par_type_d;
  logic                       stop2_q, stop2_d;
  logic [3:0]                 gap_q, gap_d;
  logic                       fdone_q, fdone_d;
  logic                       done_q, done_d;
  logic                       start_ok;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign start_ok = i_start && (i_frame_cnt != '0) &&
                    (i_frame_cnt <= FRAME_CNT_WIDTH'(MAX_FRAMES));

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    pend_d     = pend_q;
    sh_d       = sh_q;
    data_d     = data_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop2nd_d  = stop2nd_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    stop2_d    = stop2_q;
    gap_d      = gap_q;
    fdone_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start_ok) begin
          state_d    = S_START;
          pend_d     = 1'b1;
          idx_d      = '0;
          cnt_d      = i_frame_cnt;
          par_en_d   = i_par_en;
          par_type_d = i_par_type;
          stop2_d    = i_stop2;
          gap_d      = i_gap_bits;
          sh_d       = i_cmd_data[DATA_WIDTH-1:0];
          data_d     = i_cmd_data >> DATA_WIDTH;
          par_d      = parity_bit(i_cmd_data[DATA_WIDTH-1:0], i_par_type);
        end
      end

      // pend_q marks a freshly accepted command still waiting for its first tick
      S_START: begin
        if (i_baud_tick) begin
          if (pend_q) begin
            tx_d   = 1'b0;
            pend_d = 1'b0;
          end else begin
            tx_d      = sh_q[0];
            sh_d      = sh_q >> 1;
            bit_cnt_d = BIT_W'(1);
            state_d   = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (i_baud_tick) begin
          if (bit_cnt_q == BIT_W'(DATA_WIDTH)) begin
            stop2nd_d = 1'b0;
            if (par_en_q) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d      = sh_q[0];
            sh_d      = sh_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (i_baud_tick) begin
          tx_d      = 1'b1;
          stop2nd_d = 1'b0;
          state_d   = S_STOP;
        end
      end

      // The tick that ends the last stop bit also launches whatever follows
      S_STOP: begin
        if (i_baud_tick) begin
          if (stop2_q && !stop2nd_q) begin
            stop2nd_d = 1'b1;
          end else begin
            fdone_d = 1'b1;
            if (idx_q == cnt_q - FRAME_CNT_WIDTH'(1)) begin
              done_d  = 1'b1;
              tx_d    = 1'b1;
              idx_d   = '0;
              state_d = S_IDLE;
            end else begin
              sh_d   = data_q[DATA_WIDTH-1:0];
              data_d = data_q >> DATA_WIDTH;
              par_d  = parity_bit(data_q[DATA_WIDTH-1:0], par_type_q);
              if (gap_q == 4'd0) begin
                tx_d    = 1'b0;
                pend_d  = 1'b0;
                idx_d   = idx_q + FRAME_CNT_WIDTH'(1);
                state_d = S_START;
              end else begin
                tx_d      = 1'b1;
                gap_cnt_d = 4'd1;
                state_d   = S_GAP;
              end
            end
          end
        end
      end

      S_GAP: begin
        if (i_baud_tick) begin
          if (gap_cnt_q == gap_q) begin
            tx_d    = 1'b0;
            pend_d  = 1'b0;
            idx_d   = idx_q + FRAME_CNT_WIDTH'(1);
            state_d = S_START;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      pend_q     <= 1'b0;
      sh_q       <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop2nd_q  <= 1'b0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
      gap_q      <= '0;
      fdone_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      pend_q     <= pend_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop2nd_q  <= stop2nd_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      stop2_q    <= stop2_d;
      gap_q      <= gap_d;
      fdone_q    <= fdone_d;
      done_q     <= done_d;
    end
  end

  assign o_tx         = tx_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = fdone_q;
  assign o_done       = done_q;
  assign o_frame_idx  = idx_q;

endmodule

// File: tb/tb_uart_cmd_frame_gen.sv
// Scoreboard bench: a command is expanded into its per-tick line sequence,
// and a monitor compares every baud-tick response of the transmitter against it.
module tb_uart_cmd_frame_gen;

  localparam int DW  = 8;
  localparam int MF  = 4;
  localparam int FCW = 3;

  logic              CLK = 1'b0;
  logic              RST;
  logic              i_baud_tick;
  logic              i_start;
  logic [FCW-1:0]    i_frame_cnt;
  logic [MF*DW-1:0]  i_cmd_data;
  logic              i_par_en, i_par_type, i_stop2;
  logic [3:0]        i_gap_bits;
  logic              o_tx, o_busy, o_frame_done, o_done;
  logic [FCW-1:0]    o_frame_idx;

  typedef struct packed {
    logic           tx;
    logic           fd;
    logic           dn;
    logic           busy;
    logic [FCW-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   exp_fd = 0, exp_dn = 0, obs_fd = 0, obs_dn = 0;

  uart_cmd_frame_gen #(.DATA_WIDTH(DW), .MAX_FRAMES(MF), .FRAME_CNT_WIDTH(FCW)) dut (
    .CLK(CLK), .RST(RST), .i_baud_tick(i_baud_tick), .i_start(i_start),
    .i_frame_cnt(i_frame_cnt), .i_cmd_data(i_cmd_data), .i_par_en(i_par_en),
    .i_par_type(i_par_type), .i_stop2(i_stop2), .i_gap_bits(i_gap_bits),
    .o_tx(o_tx), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_done(o_done),
    .o_frame_idx(o_frame_idx)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the line value after each baud tick, from the framing rules.
  task automatic model_cmd(input int cnt, input logic [MF*DW-1:0] data,
                           input logic pe, input logic pt, input logic s2, input int gap);
    logic [DW-1:0] fr;
    logic pend;
    pend = 1'b0;
    for (int f = 0; f < cnt; f++) begin
      fr = data[f*DW +: DW];
      sb.push_back('{tx:1'b0, fd:pend, dn:1'b0, busy:1'b1, idx:FCW'(f)});
      pend = 1'b0;
      for (int b = 0; b < DW; b++)
        sb.push_back('{tx:fr[b], fd:1'b0, dn:1'b0, busy:1'b1, idx:FCW'(f)});
      if (pe)
        sb.push_back('{tx:(^fr) ^ pt, fd:1'b0, dn:1'b0, busy:1'b1, idx:FCW'(f)});
      sb.push_back('{tx:1'b1, fd:1'b0, dn:1'b0, busy:1'b1, idx:FCW'(f)});
      if (s2)
        sb.push_back('{tx:1'b1, fd:1'b0, dn:1'b0, busy:1'b1, idx:FCW'(f)});
      pend = 1'b1;
      if (f < cnt - 1) begin
        for (int g = 0; g < gap; g++) begin
          sb.push_back('{tx:1'b1, fd:pend, dn:1'b0, busy:1'b1, idx:FCW'(f)});
          pend = 1'b0;
        end
      end
    end
    sb.push_back('{tx:1'b1, fd:pend, dn:1'b1, busy:1'b0, idx:'0});
  endtask

  // Baud tick generator: random spacing between bit periods
  initial begin
    i_baud_tick = 1'b0;
    forever begin
      @(negedge CLK);
      i_baud_tick = ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor
  initial begin
    logic tk, bz, rs, ptx;
    exp_t e;
    forever begin
      @(posedge CLK);
      tk = i_baud_tick; bz = o_busy; rs = RST; ptx = o_tx;
      #1;
      if (o_frame_done) obs_fd++;
      if (o_done) obs_dn++;
      if (!rs && tk && bz) begin
        if (sb.size() == 0) begin
          chk("unexpected_tick_activity", 32'(o_busy), 32'(0));
        end else begin
          e = sb.pop_front();
          exp_fd += int'(e.fd);
          exp_dn += int'(e.dn);
          chk("tick_tx_fd_done_busy_idx",
              32'({o_tx, o_frame_done, o_done, o_busy, o_frame_idx}), 32'(e));
        end
      end else if (!rs && !tk) begin
        chk("tx_stable_between_ticks", 32'(o_tx), 32'(ptx));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while ((o_busy || sb.size() != 0) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'(o_busy), 32'(0));
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
  endtask

  task automatic scramble_inputs();
    i_frame_cnt = FCW'($urandom_range(0, 7));
    i_cmd_data  = $urandom;
    i_par_en    = 1'($urandom);
    i_par_type  = 1'($urandom);
    i_stop2     = 1'($urandom);
    i_gap_bits  = 4'($urandom);
  endtask

  task automatic send(input int cnt, input logic [MF*DW-1:0] data, input logic pe,
                      input logic pt, input logic s2, input int gap);
    bit ok;
    ok = (cnt >= 1 && cnt <= MF);
    @(negedge CLK);
    i_frame_cnt = FCW'(cnt); i_cmd_data = data; i_par_en = pe;
    i_par_type = pt; i_stop2 = s2; i_gap_bits = 4'(gap); i_start = 1'b1;
    if (ok) model_cmd(cnt, data, pe, pt, s2, gap);
    @(negedge CLK);
    i_start = 1'b0;
    if (!ok) chk("bad_count_ignored", 32'(o_busy), 32'(0));
    scramble_inputs();
  endtask

  // Start request while busy; nothing is pushed because it must be ignored
  task automatic intrude(input int after);
    repeat (after) @(negedge CLK);
    if (o_busy) begin
      i_frame_cnt = 3'd1; i_cmd_data = $urandom; i_start = 1'b1;
      @(negedge CLK);
      i_start = 1'b0;
      scramble_inputs();
    end
  endtask

  initial begin
    int base, n;
    RST = 1'b1; i_start = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge CLK);
    #2;
    chk("reset_state", 32'({o_tx, o_busy, o_frame_done, o_done, o_frame_idx}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 3'd0}));
    @(negedge CLK); RST = 1'b0;

    send(1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 0);  wait_idle();
    send(1, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 0);  wait_idle();
    send(1, 32'h0000_0077, 1'b1, 1'b1, 1'b0, 0);  wait_idle();
    send(3, 32'h0077_05AA, 1'b1, 1'b0, 1'b0, 0);  wait_idle();
    send(2, 32'h0000_3C81, 1'b0, 1'b0, 1'b1, 3);  wait_idle();
    send(0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 0);
    send(5, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 0);
    send(2, 32'h0000_1E2D, 1'b1, 1'b1, 1'b1, 1);
    intrude(6);
    wait_idle();
    send(4, 32'hFF00_C3E7, 1'b0, 1'b1, 1'b0, 15); wait_idle();

    // Abort during data bit 4 (start + bits 0..4 already on the line)
    send(1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 0);
    base = sb.size();
    n = 0;
    while (sb.size() > base - 6 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 1000) chk("abort_wait_timeout", 32'(sb.size()), 32'(base - 6));
    RST = 1'b1;
    sb.delete();
    @(posedge CLK);
    #2;
    chk("abort_outputs", 32'({o_tx, o_busy, o_frame_done, o_done, o_frame_idx}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 3'd0}));
    @(negedge CLK); RST = 1'b0;
    send(1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 0);  wait_idle();

    for (int k = 0; k < 20; k++) begin
      send($urandom_range(1, MF), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3));
      if (k % 4 == 0) intrude($urandom_range(2, 20));
      wait_idle();
    end

    repeat (5) @(negedge CLK);
    chk("frame_done_pulse_count", 32'(obs_fd), 32'(exp_fd));
    chk("done_pulse_count", 32'(obs_dn), 32'(exp_dn));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
